// File: rtl/fm_phase_ctrl_if.sv
// Sample stream interface between the audio source and fm_phase_ctrl.
//   sample_in    : signed two's-complement audio sample (source -> controller)
//   sample_valid : sample_in carries a sample         (source -> controller)
//   sample_ready : controller FIFO can take a sample  (controller -> source)
// A sample transfers on a clock edge where sample_valid && sample_ready.
interface fm_phase_ctrl_if #(
  parameter int NBITS_SAMPLE = 16
);
  logic signed [NBITS_SAMPLE-1:0] sample_in;
  logic                           sample_valid;
  logic                           sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/fm_phase_ctrl.sv
// fm_phase_ctrl: sequencing controller for the FM modulator DDS.
// Buffers signed audio samples in a small FIFO and, once per sample period
// while a run is active, turns the next sample into a 32-bit DDS phase
// increment: carrier_inc + ((sample * dev_gain) >>> dev_shift), wrapping
// modulo 2^32. The DDS clock enable is high for every cycle of a run.
// Ports:
//   clock, reset       : system clock, asynchronous active-high reset
//   start / stop       : one-cycle pulses beginning / ending a run
//   carrier_inc        : unsigned carrier increment (latched at run start)
//   dev_gain/dev_shift : deviation gain and right shift (latched at run start)
//   s_if               : sample stream (slave side: sample_in/valid/ready)
//   phaseinc           : registered phase increment to the DDS
//   enableclk          : registered DDS enable, high throughout RUN
//   busy               : registered RUN indicator
//   underrun           : sticky, a sample tick found the FIFO empty
//   fifo_level         : current FIFO occupancy
module fm_phase_ctrl #(
  parameter int NBITS_SAMPLE = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int SAMPLE_DIV   = 256
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic [31:0]                   carrier_inc,
  input  logic [15:0]                   dev_gain,
  input  logic [4:0]                    dev_shift,
  fm_phase_ctrl_if.slave                s_if,
  output logic [31:0]                   phaseinc,
  output logic                          enableclk,
  output logic                          busy,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = NBITS_SAMPLE + 17;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0]                  r_div;
  logic                           r_stop_pend;
  logic                           r_underrun;
  logic                           r_busy;
  logic                           r_enableclk;

  logic signed [NBITS_SAMPLE-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]                  r_wptr;
  logic [AW-1:0]                  r_rptr;
  logic [LW-1:0]                  r_level;

  logic [31:0]                    r_carrier_sh;
  logic [15:0]                    r_gain_sh;
  logic [4:0]                     r_shift_sh;

  logic signed [NBITS_SAMPLE-1:0] r_sample;
  logic signed [PW-1:0]           r_prod_p1;
  logic                           r_vld_p1;
  logic [31:0]                    r_phaseinc_p2;

  logic                           w_enter;
  logic                           w_tick;
  logic                           w_stop_take;
  logic                           w_stop_set;
  logic                           w_pop;
  logic                           w_under;
  logic                           w_push;
  logic signed [NBITS_SAMPLE-1:0] w_sample_cur;

  // Full-precision signed product; the gain is zero-extended so it is
  // always treated as a non-negative multiplier.
  function automatic logic signed [PW-1:0] f_mul(
    input logic signed [NBITS_SAMPLE-1:0] s,
    input logic [15:0]                    g
  );
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    a = s;
    b = $signed({{(PW-16){1'b0}}, g});
    return a * b;
  endfunction

  // Arithmetic shift then keep the low 32 bits (sign-extended if the
  // product is narrower than 32 bits). No saturation: wrap is intended.
  function automatic logic [31:0] f_dev(
    input logic signed [PW-1:0] p,
    input logic [4:0]           sh
  );
    logic signed [PW-1:0] q;
    q = p >>> sh;
    return 32'(q);
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && (r_level != '0)) w_state_nxt = S_RUN;
      S_RUN:   if (w_stop_take)              w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: control strobes ----------------
  // A stop is only taken at a sample tick; that tick neither pops nor
  // launches a new phase increment.
  always_comb begin
    w_enter     = 1'b0;
    w_tick      = 1'b0;
    w_stop_take = 1'b0;
    w_stop_set  = 1'b0;
    w_pop       = 1'b0;
    w_under     = 1'b0;
    case (r_state)
      S_IDLE: w_enter = start && (r_level != '0);
      S_RUN: begin
        w_tick      = (r_div == '0);
        w_stop_take = w_tick && r_stop_pend;
        w_pop       = w_tick && !r_stop_pend && (r_level != '0);
        w_under     = w_tick && !r_stop_pend && (r_level == '0);
        w_stop_set  = stop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div       <= '0;
      r_stop_pend <= 1'b0;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
      r_enableclk <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      if (w_enter || w_stop_take)
        r_div <= '0;
      else if (r_state == S_RUN)
        r_div <= (r_div == DW'(SAMPLE_DIV - 1)) ? '0 : r_div + DW'(1);

      if (w_stop_take)     r_stop_pend <= 1'b0;
      else if (w_stop_set) r_stop_pend <= 1'b1;

      if (w_enter)      r_underrun <= 1'b0;
      else if (w_under) r_underrun <= 1'b1;

      r_busy      <= (w_state_nxt == S_RUN);
      r_enableclk <= (w_state_nxt == S_RUN);
      r_vld_p1    <= w_tick && !r_stop_pend;
    end
  end

  // ---------------- sample FIFO ----------------
  assign s_if.sample_ready = (r_level != LW'(FIFO_DEPTH));
  assign w_push            = s_if.sample_valid && s_if.sample_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage and shadow config carry no reset; their consumers are gated
  // by reset-cleared control.
  always_ff @(posedge clock) begin
    if (w_push)  r_mem[r_wptr] <= s_if.sample_in;
    if (w_enter) begin
      r_carrier_sh <= carrier_inc;
      r_gain_sh    <= dev_gain;
      r_shift_sh   <= dev_shift;
    end
    if (w_tick)  r_prod_p1 <= f_mul(w_sample_cur, r_gain_sh);
  end

  // Hold-last: an underrun tick reuses the previous sample.
  assign w_sample_cur = w_pop ? r_mem[r_rptr] : r_sample;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sample <= '0;
    else if (w_pop) r_sample <= r_mem[r_rptr];
  end

  // ---------------- stage p1 -> p2: shift, add carrier ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_phaseinc_p2 <= '0;
    else if (r_vld_p1) r_phaseinc_p2 <= r_carrier_sh + f_dev(r_prod_p1, r_shift_sh);
  end

  assign phaseinc   = r_phaseinc_p2;
  assign enableclk  = r_enableclk;
  assign busy       = r_busy;
  assign underrun   = r_underrun;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_fm_phase_ctrl.sv
// Bench for fm_phase_ctrl: directed vectors, multi-cycle corner sequences,
// and a randomized run compared against a queue-based reference model.
module tb_fm_phase_ctrl;
  localparam int NB    = 16;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [31:0] carrier_inc = '0;
  logic [15:0] dev_gain    = '0;
  logic [4:0]  dev_shift   = '0;
  logic [31:0] phaseinc;
  logic        enableclk;
  logic        busy;
  logic        underrun;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  fm_phase_ctrl_if #(.NBITS_SAMPLE(NB)) s_if ();

  fm_phase_ctrl #(
    .NBITS_SAMPLE(NB),
    .FIFO_DEPTH  (DEPTH),
    .SAMPLE_DIV  (DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .carrier_inc(carrier_inc),
    .dev_gain   (dev_gain),
    .dev_shift  (dev_shift),
    .s_if       (s_if),
    .phaseinc   (phaseinc),
    .enableclk  (enableclk),
    .busy       (busy),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] smp;
    logic [31:0] car;
    logic [15:0] gain;
    logic [4:0]  sh;
    logic [31:0] exp_ph;
  } vec_t;

  vec_t tbl[8];

  // Reference model state
  logic [15:0] m_q[$];
  bit          m_run, m_pend, m_und, m_upd;
  int          m_pos;
  logic [15:0] m_last;
  logic [31:0] m_car, m_ph, m_updval;
  logic [15:0] m_gain;
  logic [4:0]  m_sh;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [15:0] s);
    s_if.sample_in    = s;
    s_if.sample_valid = 1'b1;
    @(negedge clock);
    s_if.sample_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] ref_phase(input logic [15:0] s, input logic [31:0] c,
                                            input logic [15:0] g, input logic [4:0] sh);
    longint p;
    p = longint'($signed(s)) * longint'(g);
    p = p >>> sh;
    return c + 32'(p);
  endfunction

  // One clock edge of the reference model, using the inputs present at it.
  task automatic model_step;
    bit tick, full_pre, nonempty_pre;
    full_pre     = (m_q.size() >= DEPTH);
    nonempty_pre = (m_q.size() != 0);
    if (m_upd) begin
      m_ph  = m_updval;
      m_upd = 1'b0;
    end
    tick = m_run && (m_pos == 0);
    if (m_run) begin
      if (tick && m_pend) begin
        m_run  = 1'b0;
        m_pend = 1'b0;
      end else begin
        if (tick) begin
          if (nonempty_pre) m_last = m_q.pop_front();
          else              m_und  = 1'b1;
          m_updval = ref_phase(m_last, m_car, m_gain, m_sh);
          m_upd    = 1'b1;
        end
        if (stop) m_pend = 1'b1;
        m_pos = (m_pos + 1) % DIV;
      end
    end else if (start && nonempty_pre) begin
      m_run  = 1'b1;
      m_pos  = 0;
      m_car  = carrier_inc;
      m_gain = dev_gain;
      m_sh   = dev_shift;
      m_und  = 1'b0;
    end
    if (s_if.sample_valid && !full_pre) m_q.push_back(s_if.sample_in);
  endtask

  initial begin
    logic [31:0] prev_ph;
    tbl[0] = '{16'h0010, 32'h01000000, 16'h0100, 5'd8,  32'h01000010};
    tbl[1] = '{16'hFFF0, 32'h01000000, 16'h0100, 5'd8,  32'h00FFFFF0};
    tbl[2] = '{16'hFFF0, 32'h00000000, 16'h0100, 5'd8,  32'hFFFFFFF0};
    tbl[3] = '{16'h7FFF, 32'h00000000, 16'hFFFF, 5'd0,  32'h7FFE8001};
    tbl[4] = '{16'h8000, 32'h00000000, 16'hFFFF, 5'd0,  32'h80008000};
    tbl[5] = '{16'h8000, 32'h80000000, 16'hFFFF, 5'd0,  32'h00008000};
    tbl[6] = '{16'h1234, 32'h10000000, 16'h0003, 5'd31, 32'h10000000};
    tbl[7] = '{16'hFFFF, 32'h00000005, 16'h0001, 5'd4,  32'h00000004};

    s_if.sample_in    = '0;
    s_if.sample_valid = 1'b0;
    @(negedge clock);
    do_reset;

    chk("reset phaseinc",   phaseinc,          32'd0);
    chk("reset enableclk",  32'(enableclk),    32'd0);
    chk("reset busy",       32'(busy),         32'd0);
    chk("reset underrun",   32'(underrun),     32'd0);
    chk("reset fifo_level", 32'(fifo_level),   32'd0);
    chk("reset ready",      32'(s_if.sample_ready), 32'd1);

    // Start with an empty FIFO is ignored
    pulse_start;
    chk("empty start busy", 32'(busy), 32'd0);

    // Directed conversion vectors: start at t, phaseinc at t+3
    prev_ph = 32'd0;
    for (int i = 0; i < 8; i++) begin
      carrier_inc = tbl[i].car;
      dev_gain    = tbl[i].gain;
      dev_shift   = tbl[i].sh;
      push(tbl[i].smp);
      pulse_start;
      chk($sformatf("vec%0d enableclk t+1", i), 32'(enableclk), 32'd1);
      chk($sformatf("vec%0d busy t+1", i),      32'(busy),      32'd1);
      cyc(1);
      chk($sformatf("vec%0d phaseinc t+2", i),  phaseinc, prev_ph);
      cyc(1);
      chk($sformatf("vec%0d phaseinc t+3", i),  phaseinc, tbl[i].exp_ph);
      prev_ph = tbl[i].exp_ph;
      pulse_stop;
      wait_idle($sformatf("vec%0d stop timeout", i));
    end

    // Config isolation and stop timing
    carrier_inc = 32'h01000000;
    dev_gain    = 16'h0100;
    dev_shift   = 5'd8;
    push(16'h0010);
    push(16'h0020);
    pulse_start;                 // t+1
    cyc(2);                      // t+3
    carrier_inc = 32'h55555555;
    chk("iso phaseinc first", phaseinc, 32'h01000010);
    cyc(4);                      // t+7
    chk("iso phaseinc second", phaseinc, 32'h01000020);
    pulse_stop;                  // t+8
    cyc(1);                      // t+9, stop tick
    chk("stop busy at tick", 32'(busy), 32'd1);
    cyc(1);                      // t+10
    chk("stop busy after", 32'(busy), 32'd0);
    chk("stop enableclk", 32'(enableclk), 32'd0);
    chk("stop phaseinc held", phaseinc, 32'h01000020);
    cyc(3);
    chk("idle phaseinc held", phaseinc, 32'h01000020);

    // Underrun: one sample, three sample periods
    carrier_inc = 32'h01000000;
    push(16'h0030);
    pulse_start;                 // t+1
    chk("und clear t+1", 32'(underrun), 32'd0);
    cyc(2);                      // t+3
    chk("und phaseinc", phaseinc, 32'h01000030);
    cyc(2);                      // t+5, empty tick
    chk("und not yet", 32'(underrun), 32'd0);
    cyc(1);                      // t+6
    chk("und set", 32'(underrun), 32'd1);
    cyc(1);                      // t+7
    chk("und hold-last", phaseinc, 32'h01000030);
    cyc(3);                      // t+10
    chk("und sticky run", 32'(underrun), 32'd1);
    pulse_stop;
    wait_idle("und stop timeout");
    chk("und sticky idle", 32'(underrun), 32'd1);
    push(16'h0010);
    pulse_start;
    chk("und cleared by start", 32'(underrun), 32'd0);
    pulse_stop;
    wait_idle("und2 stop timeout");

    // FIFO backpressure in IDLE
    s_if.sample_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_if.sample_in = 16'(16'h0100 + k);
      @(negedge clock);
    end
    s_if.sample_valid = 1'b0;
    chk("bp level full", 32'(fifo_level), 32'd4);
    chk("bp ready low", 32'(s_if.sample_ready), 32'd0);
    pulse_start;                 // t+1
    cyc(1);                      // t+2
    chk("bp ready after pop", 32'(s_if.sample_ready), 32'd1);
    chk("bp level after pop", 32'(fifo_level), 32'd3);
    cyc(1);                      // t+3
    chk("bp first sample", phaseinc, 32'h01000100);
    pulse_stop;
    wait_idle("bp stop timeout");

    // Async reset mid-run
    pulse_start;
    cyc(1);
    #2 reset = 1'b1;
    #1;
    chk("areset phaseinc",  phaseinc,        32'd0);
    chk("areset busy",      32'(busy),       32'd0);
    chk("areset enableclk", 32'(enableclk),  32'd0);
    chk("areset underrun",  32'(underrun),   32'd0);
    chk("areset level",     32'(fifo_level), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cyc(1);
    pulse_start;
    chk("areset start ignored", 32'(busy), 32'd0);
    push(16'h0010);
    pulse_start;
    chk("areset start after push", 32'(busy), 32'd1);
    pulse_stop;
    wait_idle("areset stop timeout");

    // Randomized run against the reference model
    do_reset;
    m_q.delete();
    m_run = 0; m_pend = 0; m_und = 0; m_upd = 0; m_pos = 0;
    m_last = '0; m_ph = '0; m_updval = '0; m_car = '0; m_gain = '0; m_sh = '0;
    for (int n = 0; n < 600; n++) begin
      chk("rnd phaseinc",  phaseinc,                 m_ph);
      chk("rnd busy",      32'(busy),                32'(m_run));
      chk("rnd enableclk", 32'(enableclk),           32'(m_run));
      chk("rnd underrun",  32'(underrun),            32'(m_und));
      chk("rnd level",     32'(fifo_level),          32'(m_q.size()));
      chk("rnd ready",     32'(s_if.sample_ready),   32'(m_q.size() < DEPTH));
      start             = ($urandom_range(0, 7) == 0);
      stop              = ($urandom_range(0, 11) == 0);
      s_if.sample_valid = 1'($urandom_range(0, 1));
      s_if.sample_in    = 16'($urandom);
      carrier_inc       = $urandom;
      dev_gain          = 16'($urandom);
      dev_shift         = 5'($urandom);
      @(posedge clock);
      model_step;
      @(negedge clock);
    end
    start = 1'b0;
    stop  = 1'b0;
    s_if.sample_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fm_phase_ctrl.md
# fm_phase_ctrl

Sequencing controller for the DDS phase accumulator in the all-digital FM modulator. Accepts signed audio samples over a valid/ready handshake, buffers them in a small FIFO, and at a fixed sample rate converts each sample into a 32-bit DDS phase increment: carrier increment plus scaled frequency deviation. It also drives the DDS clock-enable, so the DDS only advances while a modulation run is active. It sits between the audio source and the DDS `phaseinc`/`enableclk` inputs.

## Interface
- `NBITS_SAMPLE`, 16, width of the signed audio sample.
- `FIFO_DEPTH`, 4, sample FIFO depth in entries; must be a power of two, at least 2.
- `SAMPLE_DIV`, 256, clock cycles per sample period; at least 4.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- `stop`  in  1  one-cycle pulse that requests the end of a run; honoured only in RUN.
- `carrier_inc`  in  32  unsigned carrier phase increment.
- `dev_gain`  in  16  unsigned deviation gain.
- `dev_shift`  in  5  arithmetic right shift applied to the gain product.
- `sample_in`  in  NBITS_SAMPLE  signed two's-complement audio sample.
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  FIFO can accept a sample; high when FIFO is not full.
- `phaseinc`  out  32  registered phase increment, drives the DDS.
- `enableclk`  out  1  registered DDS enable; high on every cycle of RUN.
- `busy`  out  1  high while in RUN.
- `underrun`  out  1  sticky flag: a sample tick found the FIFO empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- The FIFO push and a pop are independent. A push happens when `sample_valid && sample_ready`. A push and a pop in the same cycle are both allowed, and the level is unchanged. A push while full is impossible because `sample_ready` is low.
- The FIFO fills in IDLE too, so the source can pre-load samples before a run.
- States are IDLE and RUN.
  - IDLE to RUN: `start` while `fifo_level` is nonzero. `start` with an empty FIFO is ignored and the block stays in IDLE.
  - On entering RUN, the block latches `carrier_inc`, `dev_gain` and `dev_shift` into shadow registers. Config changes during RUN have no effect. The entry also clears `underrun`, resets the divider to 0, and forces a sample tick on the first RUN cycle.
  - RUN to IDLE: a pending stop, taken at the next sample tick. That tick performs no pop, and the state is IDLE on the following cycle. The stop request stays pending from the `stop` pulse until that tick.
- Sample divider: counts 0 to SAMPLE_DIV-1 in RUN and wraps. A tick occurs when the count is 0. The divider is held at 0 in IDLE.
- At a tick with the FIFO nonempty, the block pops the head into the sample register.
- At a tick with the FIFO empty, the block keeps the previous sample value (hold-last) and sets `underrun`. `underrun` stays set until the next IDLE-to-RUN entry or reset.
- Arithmetic pipeline:
  - Stage 1 (cycle after the tick): product = sample (signed) × {1'b0, dev_gain}, full-width signed (NBITS_SAMPLE+17 bits), registered.
  - Stage 2: deviation = product >>> dev_shift, truncated to its low 32 bits. Then `phaseinc` = carrier_inc + deviation, modulo 2^32, with no saturation (wrap is intended).
- In IDLE, `phaseinc` holds its last value and `enableclk` is 0.
- `busy` equals (state == RUN), registered.

## Timing
- Reset (async) sets: state IDLE, FIFO empty, `fifo_level` 0, `phaseinc` 0, `enableclk` 0, `busy` 0, `underrun` 0, sample register 0, pending stop cleared. `sample_ready` reads 1 once reset deasserts.
- `start` at cycle t: `busy` and `enableclk` are 1 from t+1, the tick and pop happen at t+1, and the new `phaseinc` is visible at t+3. Pop-to-output latency is 2 cycles.
- `enableclk` deasserts on the first IDLE cycle. The final tick performs no pop and no `phaseinc` update.
- `stop` and `start` in the same cycle: in IDLE only `start` is considered; in RUN only `stop`.
- Reset mid-run aborts immediately. The FIFO is flushed and the next run needs fresh samples.
- `sample_ready` is combinational from the FIFO level. It rises in the same cycle a pop frees an entry.

## Test plan
- Basic conversion: SAMPLE_DIV=4, carrier_inc=0x01000000, gain=0x0100, shift=8, push sample 0x0010, pulse `start` at cycle t. Expect `phaseinc`=0x01000010 at t+3 and `enableclk`=1 from t+1.
- Negative sample: same config, sample 0xFFF0. Expect `phaseinc`=0x00FFFFF0. With carrier_inc=0 the result wraps to 0xFFFFFFF0.
- Underrun: one sample pushed, run 3 sample periods. Expect `underrun` set at the second tick, `phaseinc` unchanged, and `underrun` cleared by the next `start`.
- FIFO backpressure: in IDLE, hold `sample_valid` high for 6 cycles. Expect `fifo_level`=4 and `sample_ready`=0 after 4 pushes. `start` then restores `sample_ready` at the first pop.
- Stop and config isolation: change `carrier_inc` mid-run and expect no effect. Pulse `stop` mid-period and expect IDLE exactly one cycle after the next tick, `enableclk`=0, and `phaseinc` held.
- Async reset mid-run: assert `reset` between clock edges. Expect all outputs at reset values immediately, `fifo_level`=0, and `start` ignored until a sample is pushed.
